sprite_rom_arbiter: RTL

//  Shares one synchronous-read sprite ROM between NUM_REQ pixel-fetch requesters (Mario, Goomba, ground tile).

---
 rtl/sprite_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 80 ++++++++
 rtl/sprite_rom_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared definitions for the sprite ROM arbiter.
//   NUM_REQ      : number of pixel-fetch requesters sharing the ROM
//   REQ_*        : requester indices (Mario, Goomba, ground tile)
//   texel_t      : one {R,G,B} texel as stored in the sprite ROM
//   rd_tag_t     : in-flight read tag (valid + one-hot requester id)
package sprite_arb_pkg;

    localparam int NUM_REQ    = 3;
    localparam int REQ_MARIO  = 0;
    localparam int REQ_GOMBA  = 1;
    localparam int REQ_GROUND = 2;

    typedef logic [23:0] texel_t;

    typedef struct packed {
        logic               vld;
        logic [NUM_REQ-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter for the sprite ROM.
//   Clk      in   clock
//   Reset_n  in   asynchronous active-low reset
//   req      in   per-requester request vector
//   gnt      out  one-hot grant, combinational, forced to 0 during reset
// Build option: SPRITE_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins, no pointer). Default build is round-robin with a pointer that
// moves to the slot after the last granted requester.
module rr_arbiter
    import sprite_arb_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt_raw;

`ifdef SPRITE_ARB_FIXED_PRIO_EN

    logic found;

    always_comb begin
        gnt_raw = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k]) begin
                gnt_raw[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end

`else

    localparam int SUM_W = PTR_W + 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx;
    logic [SUM_W-1:0] sum;
    logic             found;

    // Walk the requesters starting at ptr_q, wrapping past NUM_REQ-1 to 0;
    // the first active request wins and the pointer moves just past it.
    always_comb begin
        gnt_raw = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                gnt_raw[idx] = 1'b1;
                found        = 1'b1;
                ptr_d        = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

    assign gnt = Reset_n ? gnt_raw : '0;

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous-read sprite ROM between the Mario, Goomba and
// ground-tile pixel fetchers and routes returned texels back to them.
//   Clk        in   clock
//   Reset_n    in   asynchronous active-low reset
//   req        in   per-requester read request (held with address until gnt)
//   req_addr   in   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt        out  one-hot grant, same cycle as req
//   rsp_valid  out  one-hot, one-cycle pulse naming the owner of rsp_data
//   rsp_data   out  returned texel (live ROM data while rsp_valid, else held)
//   rom_rd     out  registered ROM read strobe
//   rom_addr   out  registered ROM address
//   rom_data   in   ROM data, valid ROM_LAT cycles after rom_rd
// Build option: SPRITE_ARB_FIXED_PRIO_EN (see rr_arbiter) switches the
// arbitration to fixed priority; timing and routing are unchanged.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 24,
    parameter int ROM_LAT = 2
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rom_rd,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    logic              rom_rd_q, rom_rd_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] rsp_data_q;
    rd_tag_t           tag_d;
    rd_tag_t           tag_q [ROM_LAT+1];
    rd_tag_t           rsp_tag;

    rr_arbiter u_arb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .req     (req),
        .gnt     (gnt)
    );

    // gnt is one-hot, so an OR of the masked addresses is the mux.
    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                addr_sel = addr_sel | req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        rom_rd_d   = |gnt;
        rom_addr_d = (|gnt) ? addr_sel : rom_addr_q;
        tag_d.vld  = |gnt;
        tag_d.id   = gnt;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            rom_rd_q   <= rom_rd_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // Stage 0 lines up with rom_rd; stage ROM_LAT lines up with rom_data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s <= ROM_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int s = 1; s <= ROM_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign rsp_tag = tag_q[ROM_LAT];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_data_q <= '0;
        end else if (rsp_tag.vld) begin
            rsp_data_q <= rom_data;
        end
    end

    assign rsp_valid = rsp_tag.vld ? rsp_tag.id : '0;
    assign rsp_data  = rsp_tag.vld ? rom_data : rsp_data_q;
    assign rom_rd    = rom_rd_q;
    assign rom_addr  = rom_addr_q;

endmodule
